// File: rtl/instr_sequencer.sv
// instr_sequencer: queues 18-bit instruction words in a circular FIFO and
// issues them to a datapath one at a time. Each issue is a ready/valid
// handshake. After it the block waits for exec_done, with a timeout abort,
// and then for the display controller to go idle.
//
// Ports
//   clk, reset            : clock; synchronous active-high reset
//   push, push_instr      : enqueue strobe and word ([17:15] op, [14:11] dest,
//                           [10:7] src1, [6:0] src2/imm)
//   run, step, flush      : continuous issue level, single-issue pulse, queue discard
//   issue_valid/instr     : registered issue request to the datapath
//   issue_ready           : datapath accepts the presented word
//   exec_done             : writeback-complete pulse
//   lcd_busy              : display refresh in progress; holds off issue
//   full, empty, count    : FIFO status
//   busy                  : sequencer is not IDLE
//   issued_cnt            : completed-instruction counter (wraps)
//   err_overflow/timeout  : sticky error flags
module instr_sequencer #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [17:0] push_instr,
  input  logic        run,
  input  logic        step,
  input  logic        flush,
  output logic        issue_valid,
  output logic [17:0] issue_instr,
  input  logic        issue_ready,
  input  logic        exec_done,
  input  logic        lcd_busy,
  output logic        full,
  output logic        empty,
  output logic [4:0]  count,
  output logic        busy,
  output logic [15:0] issued_cnt,
  output logic        err_overflow,
  output logic        err_timeout
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [4:0]  DEPTH_C  = 5'(DEPTH);
  localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DONE, S_WAIT_LCD} state_t;

  state_t          state_q, state_d;
  logic [17:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [4:0]      count_q;
  logic            step_pend_q;
  logic [7:0]      tmo_q, tmo_d;
  logic            valid_q, valid_d;
  logic [17:0]     instr_q, instr_d;
  logic [15:0]     issued_q;
  logic            ovf_q, tmo_err_q;
  logic            full_w, empty_w;
  logic            do_push, ovf_hit, pop;
  logic            done_inc, tmo_hit;

  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == 5'd0);

  // Flush beats push, so a push during flush is neither stored nor an overflow.
  assign do_push = push && !flush && !full_w;
  assign ovf_hit = push && !flush && full_w;
  // Pop only on a completed handshake of a presented word; flush cancels it.
  assign pop     = (state_q == S_ISSUE) && valid_q && issue_ready && !flush;

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    done_inc = 1'b0;
    tmo_hit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_w && (run || step_pend_q) && !lcd_busy && !flush)
          state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (flush) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end else if (valid_q && issue_ready) begin
          state_d = S_WAIT_DONE;
          valid_d = 1'b0;
          tmo_d   = 8'd0;
        end else begin
          // First ISSUE cycle registers the head; the word then holds until taken.
          valid_d = 1'b1;
          instr_d = mem_q[rd_ptr_q];
        end
      end
      S_WAIT_DONE: begin
        if (exec_done) begin
          done_inc = 1'b1;
          state_d  = S_WAIT_LCD;
        end else if (tmo_q == TMO_LAST) begin
          tmo_hit = 1'b1;
          tmo_d   = 8'd0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_WAIT_LCD: begin
        if (!lcd_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      step_pend_q <= 1'b0;
      tmo_q       <= '0;
      valid_q     <= 1'b0;
      instr_q     <= '0;
      issued_q    <= '0;
      ovf_q       <= 1'b0;
      tmo_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
        count_q <= count_q + 5'(do_push) - 5'(pop);
      end
      if (flush || pop)         step_pend_q <= 1'b0;
      else if (step && !run)    step_pend_q <= 1'b1;
      if (done_inc) issued_q  <= issued_q + 16'd1;
      if (ovf_hit)  ovf_q     <= 1'b1;
      if (tmo_hit)  tmo_err_q <= 1'b1;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem_q[wr_ptr_q] <= push_instr;
  end

  assign issue_valid  = valid_q;
  assign issue_instr  = instr_q;
  assign full         = full_w;
  assign empty        = empty_w;
  assign count        = count_q;
  assign busy         = (state_q != S_IDLE);
  assign issued_cnt   = issued_q;
  assign err_overflow = ovf_q;
  assign err_timeout  = tmo_err_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer (DEPTH=8, TIMEOUT=255). Inputs change
// 1 ns after each rising edge and outputs are sampled there as well.
module tb_instr_sequencer;
  logic        clk = 1'b0;
  logic        reset, push, run, step, flush, issue_ready, exec_done, lcd_busy;
  logic [17:0] push_instr;
  logic        issue_valid, full, empty, busy, err_overflow, err_timeout;
  logic [17:0] issue_instr;
  logic [4:0]  count;
  logic [15:0] issued_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  instr_sequencer #(.DEPTH(8), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .push(push), .push_instr(push_instr),
    .run(run), .step(step), .flush(flush),
    .issue_valid(issue_valid), .issue_instr(issue_instr),
    .issue_ready(issue_ready), .exec_done(exec_done), .lcd_busy(lcd_busy),
    .full(full), .empty(empty), .count(count), .busy(busy),
    .issued_cnt(issued_cnt), .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!issue_valid && n < 40) begin cyc(); n++; end
    chk(tag, 32'(issue_valid), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 40) begin cyc(); n++; end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic push_word(input logic [17:0] w);
    push = 1'b1; push_instr = w;
    cyc();
    push = 1'b0;
  endtask

  logic [17:0] w [9];
  logic        seen;

  initial begin
    reset = 1'b1; push = 1'b1; push_instr = 18'h3FFFF; run = 1'b0; step = 1'b1;
    flush = 1'b0; issue_ready = 1'b0; exec_done = 1'b0; lcd_busy = 1'b0;
    cyc(); cyc();
    reset = 1'b0; push = 1'b0; step = 1'b0;
    // Reset state, with push/step ignored during reset
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full",  32'(full), 0);
    chk("rst_valid", 32'(issue_valid), 0);
    chk("rst_instr", 32'(issue_instr), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_cnt",   32'(issued_cnt), 0);
    chk("rst_errs",  32'({err_overflow, err_timeout}), 0);

    // Basic issue and two-cycle push-to-valid latency
    run = 1'b1; issue_ready = 1'b1;
    push_word(18'h08A05);
    cyc();
    chk("lat_valid_early", 32'(issue_valid), 0);
    cyc();
    chk("lat_valid", 32'(issue_valid), 1);
    chk("basic_instr", 32'(issue_instr), 32'h08A05);
    cyc();
    chk("basic_pop_empty", 32'(empty), 1);
    cyc(); cyc();
    exec_done = 1'b1; cyc(); exec_done = 1'b0;
    cyc();
    chk("basic_cnt", 32'(issued_cnt), 1);
    chk("basic_idle", 32'(busy), 0);
    exec_done = 1'b1; cyc(); exec_done = 1'b0;
    chk("done_ignored", 32'(issued_cnt), 1);

    // Overflow: 9 pushes into 8 entries, then drain in order
    run = 1'b0;
    for (int i = 0; i < 9; i++) begin
      w[i] = 18'(i * 18'h1111 + 18'h00123);
      push_word(w[i]);
    end
    chk("ovf_count", 32'(count), 8);
    chk("ovf_full",  32'(full), 1);
    chk("ovf_err",   32'(err_overflow), 1);
    run = 1'b1; exec_done = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_valid($sformatf("drain_valid%0d", i));
      chk($sformatf("drain_instr%0d", i), 32'(issue_instr), 32'(w[i]));
      cyc();
    end
    seen = 1'b0;
    repeat (20) begin cyc(); if (issue_valid) seen = 1'b1; end
    chk("drain_no_9th", 32'(seen), 0);
    chk("drain_cnt", 32'(issued_cnt), 9);
    chk("drain_empty", 32'(empty), 1);

    // Step mode: 3 queued, 2 effective steps (one redundant pulse)
    run = 1'b0;
    push_word(18'h10001); push_word(18'h20002); push_word(18'h30003);
    repeat (4) cyc();
    chk("step_hold", 32'(busy), 0);
    step = 1'b1; cyc(); step = 1'b0;
    wait_valid("step1_valid");
    chk("step1_instr", 32'(issue_instr), 32'h10001);
    wait_idle("step1_idle");
    step = 1'b1; cyc(); cyc(); step = 1'b0;
    wait_valid("step2_valid");
    chk("step2_instr", 32'(issue_instr), 32'h20002);
    repeat (15) cyc();
    chk("step_count", 32'(count), 1);
    chk("step_cnt", 32'(issued_cnt), 11);
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("flush_idle_count", 32'(count), 0);

    // Timeout: exec_done never comes; next queued word still issues
    exec_done = 1'b0; run = 1'b1;
    push_word(18'h0ABCD); push_word(18'h1BEEF);
    wait_valid("tmo_valid0");
    chk("tmo_instr0", 32'(issue_instr), 32'h0ABCD);
    cyc();
    repeat (254) cyc();
    chk("tmo_not_yet", 32'(err_timeout), 0);
    chk("tmo_busy", 32'(busy), 1);
    cyc();
    chk("tmo_err", 32'(err_timeout), 1);
    chk("tmo_idle", 32'(busy), 0);
    chk("tmo_cnt", 32'(issued_cnt), 11);
    wait_valid("tmo_valid1");
    chk("tmo_instr1", 32'(issue_instr), 32'h1BEEF);
    exec_done = 1'b1;
    wait_idle("tmo_done_idle");
    exec_done = 1'b0;
    chk("tmo_cnt2", 32'(issued_cnt), 12);

    // Flush during ISSUE: valid drops, queue cleared, step_pending cleared
    run = 1'b0;
    push_word(18'h2F00F);
    step = 1'b1; cyc(); step = 1'b0;
    wait_valid("fl_valid");
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("fl_valid_drop", 32'(issue_valid), 0);
    chk("fl_idle", 32'(busy), 0);
    chk("fl_count", 32'(count), 0);
    chk("fl_cnt", 32'(issued_cnt), 12);
    push_word(18'h05555);
    repeat (5) cyc();
    chk("fl_step_clr", 32'(busy), 0);
    chk("fl_queued", 32'(count), 1);

    // lcd_busy blocks issue, and holds WAIT_LCD
    lcd_busy = 1'b1; run = 1'b1;
    repeat (5) cyc();
    chk("lcd_block", 32'(busy), 0);
    lcd_busy = 1'b0;
    wait_valid("lcd_valid");
    chk("lcd_instr", 32'(issue_instr), 32'h05555);
    cyc();
    exec_done = 1'b1; lcd_busy = 1'b1; cyc(); exec_done = 1'b0;
    repeat (3) cyc();
    chk("lcd_hold", 32'(busy), 1);
    lcd_busy = 1'b0;
    wait_idle("lcd_release");
    chk("lcd_cnt", 32'(issued_cnt), 13);

    // Counter wrap from 0xFFFF
    force dut.issued_q = 16'hFFFF;
    cyc();
    release dut.issued_q;
    cyc();
    chk("wrap_pre", 32'(issued_cnt), 32'hFFFF);
    exec_done = 1'b1;
    push_word(18'h3C001);
    wait_valid("wrap_valid");
    wait_idle("wrap_idle");
    exec_done = 1'b0;
    chk("wrap_cnt", 32'(issued_cnt), 0);

    // Reset in WAIT_DONE with 4 queued
    run = 1'b0;
    for (int i = 0; i < 5; i++) push_word(18'(18'h01000 + i));
    step = 1'b1; cyc(); step = 1'b0;
    wait_valid("mr_valid");
    cyc();
    chk("mr_count", 32'(count), 4);
    chk("mr_busy", 32'(busy), 1);
    reset = 1'b1; push = 1'b1; step = 1'b1;
    cyc();
    reset = 1'b0; push = 1'b0; step = 1'b0;
    chk("mr_count0", 32'(count), 0);
    chk("mr_empty", 32'(empty), 1);
    chk("mr_full", 32'(full), 0);
    chk("mr_valid", 32'(issue_valid), 0);
    chk("mr_instr", 32'(issue_instr), 0);
    chk("mr_busy0", 32'(busy), 0);
    chk("mr_cnt", 32'(issued_cnt), 0);
    chk("mr_errs", 32'({err_overflow, err_timeout}), 0);

    // Step during reset ignored; flush beats simultaneous push
    push_word(18'h00777);
    repeat (5) cyc();
    chk("rst_step_ign", 32'(busy), 0);
    flush = 1'b1; push = 1'b1; push_instr = 18'h00888;
    cyc();
    flush = 1'b0; push = 1'b0;
    chk("fp_count", 32'(count), 0);
    chk("fp_no_ovf", 32'(err_overflow), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
